// File: rtl/uart_pkg.sv
// Shared UART definitions: transmitter state encoding, bit-timing helper and
// line constants common to the transmitter and receiver.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS = 8;
    localparam logic        UART_IDLE_LVL  = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    function automatic int unsigned clks_per_bit(input int unsigned clk_hz,
                                                 input int unsigned baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count and overflow pulse; DEPTH must be a
// power of two so the pointers wrap naturally.
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     wr_i,
    input  logic [WIDTH-1:0]         wr_data_i,
    input  logic                     rd_i,
    output logic [WIDTH-1:0]         rd_data_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     ovf_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wptr_q, rptr_q;
    logic [AW:0]      count_q;
    logic             ovf_q;
    logic             wr_en, rd_en;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign ovf_o     = ovf_q;
    assign rd_data_o = mem_q[rptr_q];

    // Full/empty are judged on the pre-edge count, so a simultaneous pop
    // never rescues a write made while full.
    assign wr_en = wr_i && !full_o;
    assign rd_en = rd_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            ovf_q <= wr_i && full_o;
            if (wr_en) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (rd_en) begin
                rptr_q <= rptr_q + AW'(1);
            end
            if (wr_en && !rd_en) begin
                count_q <= count_q + (AW+1)'(1);
            end else if (rd_en && !wr_en) begin
                count_q <= count_q - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: FIFO-fed 8N1 serialiser, LSB first.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1).
module uart_tx_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ = 50000000,
    parameter int unsigned BAUD   = 115200,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                      i_Clk,
    input  logic                      i_Rst,
    input  logic                      i_fWr,
    input  logic [UART_DATA_BITS-1:0] i_Data,
    output logic                      o_fFull,
    output logic                      o_fEmpty,
    output logic [$clog2(DEPTH):0]    o_Count,
    output logic                      o_fOvf,
    output logic                      o_fBusy,
    output logic                      o_fDone,
    output logic                      o_Tx
);

    localparam int unsigned CPB = clks_per_bit(CLK_HZ, BAUD);
    localparam int unsigned CW  = $clog2(CPB);

    tx_state_t                 state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic [2:0]                idx_q, idx_d;
    logic                      tx_q, tx_d;
    logic                      done_q, done_d;
    logic                      busy_q;
`ifdef UART_TX_PARITY_EN
    logic                      parity_q, parity_d;
`endif

    logic                      pop;
    logic                      bit_end;
    logic [UART_DATA_BITS-1:0] head;

    sync_fifo #(
        .WIDTH(UART_DATA_BITS),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk_i     (i_Clk),
        .rst_i     (i_Rst),
        .wr_i      (i_fWr),
        .wr_data_i (i_Data),
        .rd_i      (pop),
        .rd_data_o (head),
        .full_o    (o_fFull),
        .empty_o   (o_fEmpty),
        .count_o   (o_Count),
        .ovf_o     (o_fOvf)
    );

    assign bit_end = (cnt_q == CW'(CPB - 1));

    // Line outputs are registered from the current state, so everything on
    // the pins trails the state register by one cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = bit_end ? '0 : cnt_q + CW'(1);
        shift_d = shift_q;
        idx_d   = idx_q;
        tx_d    = UART_IDLE_LVL;
        done_d  = 1'b0;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        parity_d = parity_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!o_fEmpty) begin
                    pop     = 1'b1;
                    shift_d = head;
`ifdef UART_TX_PARITY_EN
                    parity_d = ^head;
`endif
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_end) begin
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (bit_end) begin
                    shift_d = shift_q >> 1;
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                tx_d = parity_q;
                if (bit_end) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    done_d = 1'b1;
                    if (!o_fEmpty) begin
                        pop     = 1'b1;
                        shift_d = head;
`ifdef UART_TX_PARITY_EN
                        parity_d = ^head;
`endif
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (state_d != state_q) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            shift_q <= '0;
            idx_q   <= '0;
            tx_q    <= UART_IDLE_LVL;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
            idx_q   <= idx_d;
            tx_q    <= tx_d;
            done_q  <= done_d;
            busy_q  <= (state_q != IDLE);
`ifdef UART_TX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign o_Tx    = tx_q;
    assign o_fDone = done_q;
    assign o_fBusy = busy_q;

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Buffered UART transmitter, the outbound counterpart to the byte receiver feeding the FND display path. The user side writes bytes into an internal FIFO. The block serialises them onto o_Tx as 8N1 frames (optionally 8E1), LSB first. It sits between push-button/keypad logic and the board TX pin, so producers never wait on the line.

Parameters:
CLK_HZ, 50000000, system clock frequency in Hz
BAUD, 115200, line rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer divide, must be >= 2)
DEPTH, 8, FIFO entries; power of two, >= 2

Ports:
i_Clk  in  1  system clock, all logic on rising edge
i_Rst  in  1  synchronous reset, active-high
i_fWr  in  1  write strobe; byte on i_Data is enqueued this cycle if not full
i_Data  in  8  byte to transmit
o_fFull  out  1  FIFO holds DEPTH bytes
o_fEmpty  out  1  FIFO holds 0 bytes
o_Count  out  $clog2(DEPTH)+1  FIFO occupancy
o_fOvf  out  1  one-cycle pulse: write attempted while full, byte dropped
o_fBusy  out  1  high while a frame is on the line (state != IDLE)
o_fDone  out  1  one-cycle pulse on the last cycle of each stop bit
o_Tx  out  1  serial line, idle high, registered output

Behaviour:
- Reset (i_Rst=1 at edge): o_Tx=1, state IDLE, FIFO pointers/count=0, o_fFull=0, o_fEmpty=1, o_fOvf=0, o_fBusy=0, o_fDone=0. Reset mid-frame aborts the frame; o_Tx is high the cycle after the reset edge; queued bytes are discarded.
- FIFO: write accepted iff i_fWr && !o_fFull at the edge. Full is judged on the pre-edge count. A write while full is dropped and pulses o_fOvf, even if a pop happens the same cycle. A pop plus a write in the same cycle leaves the count unchanged. Pointers wrap modulo DEPTH.
- Baud counter: counts 0..CLKS_PER_BIT-1. It is cleared on every state entry. bit_end = (cnt == CLKS_PER_BIT-1).
- States: IDLE, START, DATA, PARITY (macro only), STOP.
- IDLE: o_Tx=1. If FIFO is non-empty at the edge, pop the head into the shift register and go to START. A byte written into an empty idle block starts its start bit 2 cycles after the write edge.
- START: o_Tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
- DATA: o_Tx = shift[0]. On bit_end, shift right and increment the index. After index 7 completes, go to PARITY (macro) or STOP.
- STOP: o_Tx=1 for CLKS_PER_BIT cycles. On bit_end, pulse o_fDone. If the FIFO is non-empty, pop and go directly to START (back-to-back frames, no idle gap); otherwise go to IDLE.
- Frame length: 10*CLKS_PER_BIT cycles (11 with parity).
- o_Tx is driven from a flop updated with the state, with no combinational path from inputs.
- Writes during a frame never disturb the frame in flight.

Optional Feature:
UART_TX_PARITY_EN
- Defined: PARITY state is inserted after DATA and drives the even-parity bit (XOR of the 8 data bits, captured at pop) for CLKS_PER_BIT cycles. Frame becomes 8E1, 11 bit-times.
- Undefined: the PARITY state and parity logic do not exist; frame is 8N1.

Decomposition:
- Package uart_pkg:
  - state enum tx_state_t {IDLE, START, DATA, PARITY, STOP};
  - function clks_per_bit(CLK_HZ, BAUD);
  - constants UART_DATA_BITS=8 and UART_IDLE_LVL=1'b1, shared with the receiver.
- Sub-module sync_fifo (parameters WIDTH, DEPTH): holds storage, pointers, count, full/empty. It is reusable for a future buffered receiver. The top holds the FSM, baud counter, shift register and parity.

Test Plan:
All scenarios use CLK_HZ=1000000, BAUD=100000 (10 clocks/bit), DEPTH=4.
1. Reset, then write 0x55 once -> o_Tx goes low 2 cycles after the write edge for 10 cycles. Data bits read 1,0,1,0,1,0,1,0 (10 cycles each), then stop high. o_fDone pulses at frame cycle 100, o_fBusy falls the next cycle.
2. Write 0xA3, 0x0F on consecutive cycles -> two frames back-to-back with no idle gap between the stop bit and the next start bit. The receiver model decodes 0xA3 then 0x0F. o_Count goes 1,1(pop+write),1,0.
3. Write 6 bytes 0x01..0x06 in consecutive cycles while idle -> the first is popped after one cycle. Writes 1-5 are accepted and write 6 pulses o_fOvf with o_fFull=1. The line carries 0x01..0x05 only.
4. Assert i_Rst for 1 cycle mid-DATA of 0xFF with 2 bytes queued -> o_Tx=1 the next cycle, o_Count=0, o_fEmpty=1. No further frames are sent.
5. Write while full in the same cycle the FSM pops -> byte dropped, o_fOvf=1, o_Count decrements by 1.
6. With UART_TX_PARITY_EN defined, send 0x07 -> parity bit 1 and frame 110 cycles. Send 0x03 -> parity bit 0.
